// File: rtl/segment_dp.sv
// Dynamic-programming segmentation of I bins into K contiguous segments.
// Costs are fetched from an external fixed-latency engine; boundaries stream out after traceback.
module segment_dp #(
    parameter int BIT_WIDTH  = 32,
    parameter int I          = 160,
    parameter int MAX_SEG    = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [$clog2(MAX_SEG+1)-1:0]   num_seg,
    output logic                           cost_req_valid,
    output logic [$clog2(I)-1:0]           cost_req_a,
    output logic [$clog2(I)-1:0]           cost_req_b,
    input  logic [BIT_WIDTH-1:0]           cost_resp,
    output logic                           seg_valid,
    input  logic                           seg_ready,
    output logic [$clog2(I)-1:0]           seg_start,
    output logic [$clog2(I)-1:0]           seg_end,
    output logic [$clog2(MAX_SEG)-1:0]     seg_idx,
    output logic                           seg_last,
    output logic [BIT_WIDTH-1:0]           total_cost,
    output logic                           err,
    output logic                           busy
);
    // state   | meaning
    // IDLE    | waiting for start, start_ready high
    // INIT    | fetching E(0,i) into row 1 of F
    // ROW     | filling row k of F/B, then draining the response pipe
    // TRACE   | walking B back from (K, I-1) into the boundary array
    // OUT     | streaming K segment records downstream
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(MAX_SEG + 1);
    localparam int SW = $clog2(MAX_SEG);
    localparam int TL = RD_LATENCY - 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROW, S_TRACE, S_OUT} state_t;
    state_t state, state_nx;

    logic [BIT_WIDTH-1:0] f_tab [MAX_SEG][I];
    logic [IW-1:0]        b_tab [MAX_SEG][I];
    logic [IW-1:0]        bnd   [MAX_SEG];

    logic [KW-1:0]        k_lat, k_cur, tk;
    logic [IW-1:0]        cur_i, cur_j, row_j0;
    logic [SW-1:0]        oidx, prev_row, wr_row;
    logic                 issue_done, req_fire, row_done, pipe_busy, bad_k, take;
    logic [BIT_WIDTH-1:0] tot, best, cand, addend, sum;
    logic [BIT_WIDTH:0]   wide_sum;
    logic [IW-1:0]        bestj, candj;

    // tag pipe travelling alongside each outstanding cost request
    logic                 pv     [RD_LATENCY];
    logic                 pinit  [RD_LATENCY];
    logic                 pfirst [RD_LATENCY];
    logic                 plast  [RD_LATENCY];
    logic [IW-1:0]        pi     [RD_LATENCY];
    logic [IW-1:0]        pj     [RD_LATENCY];
    logic [BIT_WIDTH-1:0] pf     [RD_LATENCY];

    assign bad_k    = (num_seg == '0) || (int'(num_seg) > MAX_SEG) || (int'(num_seg) > I);
    assign req_fire = ((state == S_INIT) || (state == S_ROW)) && !issue_done;
    assign row_done = issue_done && !pipe_busy;
    assign row_j0   = (state == S_ROW) ? IW'(k_cur - KW'(2)) : '0;
    assign prev_row = (state == S_ROW) ? SW'(k_cur - KW'(2)) : '0;
    assign wr_row   = SW'(k_cur - 1'b1);

    always_comb begin
        pipe_busy = 1'b0;
        for (int n = 0; n < RD_LATENCY; n++) pipe_busy = pipe_busy | pv[n];
    end

    assign addend   = pinit[TL] ? '0 : pf[TL];
    assign wide_sum = {1'b0, addend} + {1'b0, cost_resp};
    assign sum      = wide_sum[BIT_WIDTH] ? '1 : wide_sum[BIT_WIDTH-1:0];
    // strict less-than keeps the earliest j on ties
    assign take     = pfirst[TL] || (sum < best);
    assign cand     = take ? sum : best;
    assign candj    = take ? pj[TL] : bestj;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:        if (start_valid && !bad_k) state_nx = S_INIT;
            S_INIT, S_ROW: if (row_done) state_nx = (k_cur == k_lat) ? S_TRACE : S_ROW;
            S_TRACE:       if (tk <= KW'(1)) state_nx = S_OUT;
            S_OUT:         if (seg_ready && (KW'(oidx) == k_lat - 1'b1)) state_nx = S_IDLE;
            default:       state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err        <= 1'b0;
            k_lat      <= '0;
            k_cur      <= '0;
            tk         <= '0;
            cur_i      <= '0;
            cur_j      <= '0;
            oidx       <= '0;
            issue_done <= 1'b0;
            tot        <= '0;
            best       <= '0;
            bestj      <= '0;
            for (int n = 0; n < RD_LATENCY; n++) begin
                pv[n] <= 1'b0; pinit[n] <= 1'b0; pfirst[n] <= 1'b0; plast[n] <= 1'b0;
                pi[n] <= '0;   pj[n] <= '0;      pf[n] <= '0;
            end
            for (int m = 0; m < MAX_SEG; m++) bnd[m] <= '0;
        end else begin
            err       <= 1'b0;
            pv[0]     <= req_fire;
            pinit[0]  <= (state == S_INIT);
            pfirst[0] <= (state == S_INIT) || (cur_j == row_j0);
            plast[0]  <= (state == S_INIT) || (cur_j == cur_i - 1'b1);
            pi[0]     <= cur_i;
            pj[0]     <= cur_j;
            pf[0]     <= f_tab[prev_row][cur_j];
            for (int n = 1; n < RD_LATENCY; n++) begin
                pv[n] <= pv[n-1]; pinit[n] <= pinit[n-1]; pfirst[n] <= pfirst[n-1];
                plast[n] <= plast[n-1]; pi[n] <= pi[n-1]; pj[n] <= pj[n-1]; pf[n] <= pf[n-1];
            end
            if (pv[TL]) begin
                best  <= cand;
                bestj <= candj;
            end
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        if (bad_k) begin
                            err <= 1'b1;
                        end else begin
                            k_lat      <= num_seg;
                            k_cur      <= KW'(1);
                            cur_i      <= '0;
                            cur_j      <= '0;
                            issue_done <= 1'b0;
                        end
                    end
                end
                S_INIT, S_ROW: begin
                    if (req_fire) begin
                        if ((state == S_INIT) || (cur_j == cur_i - 1'b1)) begin
                            if (cur_i == IW'(I - 1)) issue_done <= 1'b1;
                            else begin
                                cur_i <= cur_i + 1'b1;
                                cur_j <= row_j0;
                            end
                        end else begin
                            cur_j <= cur_j + 1'b1;
                        end
                    end
                    if (row_done) begin
                        if (k_cur == k_lat) begin
                            tk   <= k_lat;
                            oidx <= '0;
                            tot  <= f_tab[SW'(k_lat - 1'b1)][IW'(I - 1)];
                            bnd[SW'(k_lat - 1'b1)] <= IW'(I - 1);
                        end else begin
                            // the final row only needs its i = I-1 column
                            k_cur      <= k_cur + 1'b1;
                            cur_i      <= (k_cur + 1'b1 == k_lat) ? IW'(I - 1) : IW'(k_cur);
                            cur_j      <= IW'(k_cur - 1'b1);
                            issue_done <= 1'b0;
                        end
                    end
                end
                S_TRACE: begin
                    if (tk > KW'(1)) begin
                        bnd[SW'(tk - KW'(2))] <= b_tab[SW'(tk - 1'b1)][bnd[SW'(tk - 1'b1)]];
                        tk <= tk - 1'b1;
                    end
                end
                S_OUT: if (seg_ready) oidx <= oidx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (pv[TL] && plast[TL]) begin
            f_tab[wr_row][pi[TL]] <= cand;
            b_tab[wr_row][pi[TL]] <= candj;
        end
    end

    assign start_ready    = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign cost_req_valid = req_fire;
    assign cost_req_a     = (req_fire && (state == S_ROW)) ? cur_j + 1'b1 : '0;
    assign cost_req_b     = req_fire ? cur_i : '0;
    assign seg_valid      = (state == S_OUT);
    assign seg_idx        = seg_valid ? oidx : '0;
    assign seg_start      = (seg_valid && (oidx != '0)) ? bnd[oidx - 1'b1] + 1'b1 : '0;
    assign seg_end        = seg_valid ? bnd[oidx] : '0;
    assign seg_last       = seg_valid && (KW'(oidx) == k_lat - 1'b1);
    assign total_cost     = seg_valid ? tot : '0;

endmodule

// File: tb/tb_segment_dp.sv
// Directed bench for segment_dp with I=8: a modelled cost engine and a record scoreboard.
module tb_segment_dp;
    localparam int BW = 32;
    localparam int NB = 8;
    localparam int MS = 8;
    localparam int RL = 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start_valid;
    logic          start_ready;
    logic [3:0]    num_seg;
    logic          cost_req_valid;
    logic [2:0]    cost_req_a, cost_req_b;
    logic [BW-1:0] cost_resp;
    logic          seg_valid, seg_ready;
    logic [2:0]    seg_start, seg_end, seg_idx;
    logic          seg_last;
    logic [BW-1:0] total_cost;
    logic          err, busy;

    segment_dp #(.BIT_WIDTH(BW), .I(NB), .MAX_SEG(MS), .RD_LATENCY(RL)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .start_valid(start_valid), .start_ready(start_ready), .num_seg(num_seg),
        .cost_req_valid(cost_req_valid), .cost_req_a(cost_req_a), .cost_req_b(cost_req_b),
        .cost_resp(cost_resp),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_start(seg_start), .seg_end(seg_end),
        .seg_idx(seg_idx), .seg_last(seg_last), .total_cost(total_cost),
        .err(err), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // cost engine: mode 0 (b-a)^2, 1 constant 1, 2 all ones, 3 constant 42
    int            cost_mode;
    logic [BW-1:0] d0, d1;

    function automatic logic [BW-1:0] cost_fn(input int mode, input int a, input int b);
        case (mode)
            0:       return BW'((b - a) * (b - a));
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return 32'd42;
        endcase
    endfunction

    always @(posedge clk_in) begin
        d0 <= cost_req_valid ? cost_fn(cost_mode, int'(cost_req_a), int'(cost_req_b)) : 32'hDEAD_BEEF;
        d1 <= d0;
    end
    assign cost_resp = d1;

    int         err_cnt = 0, req_cnt = 0, busy_cnt = 0, seg_cnt = 0;
    logic [5:0] req_log [$];

    always @(negedge clk_in) begin
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (seg_valid) seg_cnt++;
        if (cost_req_valid) begin
            req_cnt++;
            req_log.push_back({cost_req_a, cost_req_b});
        end
    end

    typedef struct {
        logic [2:0]    s, e, idx;
        logic          last;
        logic [BW-1:0] tot;
    } rec_t;
    rec_t exp_q [$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_rec(input int s, input int e, input int idx, input bit last, input logic [BW-1:0] tot);
        rec_t r;
        r.s = 3'(s); r.e = 3'(e); r.idx = 3'(idx); r.last = last; r.tot = tot;
        exp_q.push_back(r);
    endtask

    task automatic run_frame(input int k, input int mode, input bit stall);
        bit   done;
        int   stalls;
        rec_t r;
        cost_mode = mode;
        @(negedge clk_in);
        num_seg = 4'(k);
        start_valid = 1'b1;
        @(negedge clk_in);
        start_valid = 1'b0;
        done = 1'b0;
        stalls = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk_in);
            seg_ready = 1'b1;
            if (seg_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_record", 32'(seg_valid), 32'd0);
                    done = 1'b1;
                end else begin
                    r = exp_q[0];
                    chk("seg_start", 32'(seg_start), 32'(r.s));
                    chk("seg_end", 32'(seg_end), 32'(r.e));
                    chk("seg_idx", 32'(seg_idx), 32'(r.idx));
                    chk("seg_last", 32'(seg_last), 32'(r.last));
                    chk("total_cost", total_cost, r.tot);
                    if (stall && r.idx == 3'd1 && stalls < 3) begin
                        seg_ready = 1'b0;
                        stalls++;
                    end else begin
                        void'(exp_q.pop_front());
                        if (r.last) done = 1'b1;
                    end
                end
            end
        end
        chk("frame_done", 32'(done), 32'd1);
        @(negedge clk_in);
        chk("start_ready_after", 32'(start_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int  base, e0, r0, b0, s0;
        bit  found;
        int  bad_k [2];
        rst_n_in    = 1'b0;
        start_valid = 1'b0;
        num_seg     = '0;
        seg_ready   = 1'b1;
        cost_mode   = 0;
        repeat (3) @(negedge clk_in);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seg_valid", 32'(seg_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_valid", 32'(cost_req_valid), 32'd0);
        chk("rst_total", total_cost, 32'd0);
        rst_n_in = 1'b1;

        // squared-distance costs split the 8 bins evenly
        push_rec(0, 3, 0, 1'b0, 32'd18);
        push_rec(4, 7, 1, 1'b1, 32'd18);
        run_frame(2, 0, 1'b0);

        // flat costs: every split ties, the earliest wins
        push_rec(0, 0, 0, 1'b0, 32'd2);
        push_rec(1, 7, 1, 1'b1, 32'd2);
        run_frame(2, 1, 1'b0);

        base = req_log.size();
        push_rec(0, 7, 0, 1'b1, 32'd42);
        run_frame(1, 3, 1'b0);
        chk("k1_req_count", 32'(req_log.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < req_log.size())
                chk("k1_req_ab", 32'(req_log[base + i]), 32'(i));

        bad_k[0] = 0;
        bad_k[1] = MS + 1;
        for (int v = 0; v < 2; v++) begin
            e0 = err_cnt; r0 = req_cnt; b0 = busy_cnt;
            @(negedge clk_in);
            num_seg = 4'(bad_k[v]);
            start_valid = 1'b1;
            @(negedge clk_in);
            start_valid = 1'b0;
            repeat (5) @(negedge clk_in);
            chk("bad_k_err_pulses", 32'(err_cnt - e0), 32'd1);
            chk("bad_k_requests", 32'(req_cnt - r0), 32'd0);
            chk("bad_k_busy", 32'(busy_cnt - b0), 32'd0);
            chk("bad_k_start_ready", 32'(start_ready), 32'd1);
        end

        // saturating totals with a three-cycle stall on the middle record
        push_rec(0, 0, 0, 1'b0, 32'hFFFF_FFFF);
        push_rec(1, 1, 1, 1'b0, 32'hFFFF_FFFF);
        push_rec(2, 7, 2, 1'b1, 32'hFFFF_FFFF);
        run_frame(3, 2, 1'b1);

        cost_mode = 0;
        s0 = seg_cnt;
        @(negedge clk_in);
        num_seg = 4'd2;
        start_valid = 1'b1;
        @(negedge clk_in);
        start_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk_in);
            if (cost_req_valid && cost_req_a != 3'd0) found = 1'b1;
        end
        chk("row_reached", 32'(found), 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        chk("abort_req_valid", 32'(cost_req_valid), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("abort_no_records", 32'(seg_cnt - s0), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        push_rec(0, 3, 0, 1'b0, 32'd18);
        push_rec(4, 7, 1, 1'b1, 32'd18);
        run_frame(2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/segment_dp.md
Name: segment_dp

Overview:
- Parametrised successor to the formant-segmentation dynamic-programming core.
- Partitions I spectral bins into a runtime-selectable number of contiguous segments (1..MAX_SEG) minimising total segment cost.
- Fetches segment costs E(a,b) from an external fixed-latency cost engine (emin-style).
- Keeps F/B tables internally, performs traceback, and streams segment boundaries to the downstream phi stage over a valid/ready handshake.

Parameters:
- BIT_WIDTH, 32, width of costs and totals (unsigned).
- I, 160, number of bins; bin indices are 0..I-1.
- MAX_SEG, 8, maximum number of segments; sizes the F/B tables (MAX_SEG x I entries each).
- RD_LATENCY, 2, fixed cycles from cost request to cost response (>=1).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_valid  in  1  start request.
- start_ready  out  1  high only in IDLE.
- num_seg  in  $clog2(MAX_SEG+1)  segment count K; sampled on start handshake.
- cost_req_valid  out  1  cost request strobe.
- cost_req_a  out  $clog2(I)  segment first bin.
- cost_req_b  out  $clog2(I)  segment last bin (inclusive).
- cost_resp  in  BIT_WIDTH  E(a,b); valid exactly RD_LATENCY cycles after the matching request, no backpressure.
- seg_valid  out  1  segment record valid.
- seg_ready  in  1  downstream accept.
- seg_start  out  $clog2(I)  first bin of segment.
- seg_end  out  $clog2(I)  last bin of segment.
- seg_idx  out  $clog2(MAX_SEG)  0-based segment number.
- seg_last  out  1  final record of the frame.
- total_cost  out  BIT_WIDTH  F(K,I-1); valid while seg_valid is high.
- err  out  1  one-cycle pulse on rejected start.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0 except start_ready=1. Reset mid-frame abandons all work; no records are emitted. Responses for requests already in flight are ignored.
- Start: handshake is start_valid && start_ready. If num_seg==0, num_seg>MAX_SEG or num_seg>I, pulse err for 1 cycle and stay in IDLE. Otherwise latch K and go to INIT.
- Recurrence:
  - F(1,i)=E(0,i).
  - For k>=2 and i>=k-1: F(k,i)=min over j=k-2..i-1 of F(k-1,j)+E(j+1,i), and B(k,i)=argmin j.
  - Ties: smallest j wins (strict less-than compare).
  - Addition saturates at 2^BIT_WIDTH-1.
- INIT: issue (a=0,b=i) for i=0..I-1 in order. When the last response is written, go to ROW with k=2, or to TRACE if K==1.
- ROW k: for i=k-1..I-1, and for each i j=k-2..i-1 ascending, issue (a=j+1,b=i).
  - Pair each response with F(k-1,j) via an internal RD_LATENCY-deep tag pipeline.
  - Write F(k,i) and B(k,i) after the last j for that i.
  - Only row k=K needs i=I-1 (other i may be skipped when k==K).
  - After row K, go to TRACE.
- Request ordering is fixed as above. Gaps are allowed (at most one request per cycle). Compute for I=160, K=5 must finish in <=70,000 cycles.
- TRACE:
  - b_K=I-1 and b_{k-1}=B(k,b_k) for k=K..2.
  - Store the boundaries in a MAX_SEG register array, taking 1 cycle per step plus table read latency.
  - Then go to OUT.
- OUT:
  - Emit K records in order seg_idx=0..K-1.
  - seg_start = 0 for idx 0, else b_idx+1 (with b indexed 1..K).
  - seg_end = b_(idx+1).
  - seg_last=1 on idx K-1.
  - Record transfers on seg_valid&&seg_ready. All seg_* outputs and total_cost stay stable while seg_valid&&!seg_ready.
  - After the last transfer, return to IDLE; start_ready rises the next cycle.
- start_valid outside IDLE is ignored. A new start is not accepted in the cycle of the last transfer.

Test Plan:
- I=8, K=2, E(a,b)=(b-a)^2 -> records {0,[0,3]}, {1,[4,7],last}; total_cost=18.
- I=8, K=2, E≡1 -> tie resolves to smallest j: {[0,0]}, {[1,7]}; total_cost=2.
- I=8, K=1, E(0,7)=42 -> exactly 8 requests (0,0)..(0,7); single record [0,7], last=1, total_cost=42.
- num_seg=0, then num_seg=MAX_SEG+1 -> err pulses once each, busy stays 0, no cost requests issued.
- E≡32'hFFFF_FFFF, K=3 -> total_cost=32'hFFFF_FFFF (no wrap). Hold seg_ready=0 for 3 cycles on idx 1 -> outputs unchanged until accept.
- Deassert rst_n_in mid-ROW, then run a fresh I=8, K=2 frame -> busy=0 and start_ready=1 immediately on reset; second frame matches the first scenario exactly.
